gray_counter_ctrl: RTL and testbench

- Run controller and checker for the 5-bit gray counters (conditional and structural versions).
- On a start command it drives the counter's enable for exactly num_counts cycles, then checks every counter advance against the expected next gray code. It counts mismatches and reports done.
- Sits between the probador and one gray counter instance; one controller is instantiated per counter implementation.

---
 rtl/gray_counter_ctrl_if.sv | 27 ++
 rtl/gray_counter_ctrl.sv | 133 +++++++++++++
 tb/tb_gray_counter_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/gray_counter_ctrl_if.sv
// Bundle between the probador, one gray counter instance and its run controller.
interface gray_counter_ctrl_if #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] num_counts;
  logic             stop;
  logic [WIDTH-1:0] gray_in;
  logic             enable;
  logic             busy;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] error_count;
  logic             aborted;
  logic [WIDTH-1:0] last_gray;

  modport master (
    output start, num_counts, stop, gray_in,
    input  enable, busy, done, error, error_count, aborted, last_gray
  );

  modport slave (
    input  start, num_counts, stop, gray_in,
    output enable, busy, done, error, error_count, aborted, last_gray
  );
endinterface

// File: rtl/gray_counter_ctrl.sv
// Run controller for a gray counter: issues num_counts enables, then checks
// each counter advance against the expected next gray code.
module gray_counter_ctrl #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset_L,
  gray_counter_ctrl_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic             enable_q, enable_d;
  logic             en_d1_q;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;
  logic             aborted_q, aborted_d;
  logic [WIDTH-1:0] next_bin;
  logic [WIDTH-1:0] exp_gray;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = g;
    for (int unsigned i = 1; i < WIDTH; i++) b = b ^ (g >> i);
    return b;
  endfunction

  assign next_bin = gray2bin(ref_q) + WIDTH'(1);
  assign exp_gray = next_bin ^ (next_bin >> 1);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= S_IDLE;
      enable_q    <= 1'b0;
      en_d1_q     <= 1'b0;
      remaining_q <= '0;
      ref_q       <= '0;
      last_q      <= '0;
      error_q     <= 1'b0;
      ecnt_q      <= '0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      enable_q    <= enable_d;
      en_d1_q     <= enable_q;
      remaining_q <= remaining_d;
      ref_q       <= ref_d;
      last_q      <= last_d;
      error_q     <= error_d;
      ecnt_q      <= ecnt_d;
      aborted_q   <= aborted_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    enable_d    = 1'b0;
    remaining_d = remaining_q;
    ref_d       = ref_q;
    last_d      = last_q;
    error_d     = error_q;
    ecnt_d      = ecnt_q;
    aborted_d   = aborted_q;

    // Reference follows the observed value even on a mismatch, so a single
    // glitch counts once instead of cascading through the rest of the run.
    if (en_d1_q) begin
      if (bus.gray_in != exp_gray) begin
        error_d = 1'b1;
        if (ecnt_q != '1) ecnt_d = ecnt_q + CNT_W'(1);
      end
      ref_d  = bus.gray_in;
      last_d = bus.gray_in;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          error_d   = 1'b0;
          ecnt_d    = '0;
          aborted_d = 1'b0;
          if (bus.num_counts != '0) begin
            remaining_d = bus.num_counts;
            state_d     = S_SYNC;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SYNC: begin
        ref_d  = bus.gray_in;
        last_d = bus.gray_in;
        if (bus.stop) begin
          aborted_d = 1'b1;
          state_d   = S_DRAIN;
        end else begin
          enable_d = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        remaining_d = remaining_q - CNT_W'(1);
        if (bus.stop) begin
          aborted_d = 1'b1;
          state_d   = S_DRAIN;
        end else if (remaining_q == CNT_W'(1)) begin
          state_d = S_DRAIN;
        end else begin
          enable_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (!en_d1_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.enable      = enable_q;
  assign bus.busy        = (state_q == S_SYNC) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done        = (state_q == S_DONE);
  assign bus.error       = error_q;
  assign bus.error_count = ecnt_q;
  assign bus.aborted     = aborted_q;
  assign bus.last_gray   = last_q;

endmodule

// File: tb/tb_gray_counter_ctrl.sv
// Directed bench: a behavioural gray counter with fault mask feeds the
// controller; per-run expectations are queued at start and checked at done.
module tb_gray_counter_ctrl;

  localparam int unsigned WIDTH = 5;
  localparam int unsigned CNT_W = 8;

  typedef struct {
    int               enables;
    int               done_cyc;
    logic             err;
    logic [CNT_W-1:0] ecnt;
    logic [WIDTH-1:0] last;
    logic             ab;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_L;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] mask;
  logic             ld;
  logic [WIDTH-1:0] ld_val;
  exp_t             sb[$];
  int               checks = 0;
  int               errors = 0;

  gray_counter_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  gray_counter_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Behavioural counter: advances on a sampled enable, value visible before next edge.
  always @(posedge clk) begin
    if (ld) cnt <= ld_val;
    else if (bus.enable) cnt <= cnt + 5'd1;
  end
  assign bus.gray_in = (cnt ^ (cnt >> 1)) & ~mask;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preset(input logic [WIDTH-1:0] v);
    @(negedge clk);
    ld = 1'b1;
    ld_val = v;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic do_run(input int n, input int stop_cyc, input int restart_cyc, input exp_t e);
    int   en_cnt, dc;
    logic got, busy_seen;
    exp_t x;
    en_cnt = 0; dc = 0; got = 1'b0; busy_seen = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.num_counts = CNT_W'(n);
    sb.push_back(e);
    for (int k = 1; k <= 60 && !got; k++) begin
      @(negedge clk);
      bus.start = (k == restart_cyc);
      bus.num_counts = (k == restart_cyc) ? 8'd20 : CNT_W'(n);
      bus.stop = (k == stop_cyc);
      if (bus.enable) en_cnt++;
      if (bus.busy) busy_seen = 1'b1;
      if (bus.done) begin
        got = 1'b1;
        dc = k;
      end
    end
    bus.start = 1'b0;
    bus.stop = 1'b0;
    x = sb.pop_front();
    chk("done_seen", got, 1);
    chk("done_cycle", dc, x.done_cyc);
    chk("enables", en_cnt, x.enables);
    chk("error", bus.error, x.err);
    chk("error_count", bus.error_count, x.ecnt);
    chk("last_gray", bus.last_gray, x.last);
    chk("aborted", bus.aborted, x.ab);
    if (n == 0) chk("busy_never", busy_seen, 0);
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);
  endtask

  initial begin
    reset_L = 1'b0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.num_counts = '0;
    mask = '0;
    ld = 1'b0;
    ld_val = '0;
    preset(5'd0);
    #1;
    chk("rst_enable", bus.enable, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_error_count", bus.error_count, 0);
    chk("rst_aborted", bus.aborted, 0);
    chk("rst_last_gray", bus.last_gray, 0);
    @(negedge clk);
    reset_L = 1'b1;

    // Basic 8-count run from zero.
    do_run(8, 0, 0, '{enables: 8, done_cyc: 12, err: 1'b0, ecnt: 8'd0, last: 5'b01100, ab: 1'b0});

    // Wrap through 10000 -> 00000 -> 00001.
    preset(5'd30);
    do_run(3, 0, 0, '{enables: 3, done_cyc: 7, err: 1'b0, ecnt: 8'd0, last: 5'b00001, ab: 1'b0});

    // Bit 2 stuck at zero: five mismatch events.
    preset(5'd0);
    mask = 5'b00100;
    do_run(8, 0, 0, '{enables: 8, done_cyc: 12, err: 1'b1, ecnt: 8'd5, last: 5'b01000, ab: 1'b0});
    mask = '0;

    // Stop in third RUN cycle (cycle 4) of a 20-count run.
    preset(5'd0);
    do_run(20, 4, 0, '{enables: 3, done_cyc: 7, err: 1'b0, ecnt: 8'd0, last: 5'b00010, ab: 1'b1});

    // Zero-length run: straight to done, status from previous run cleared except last_gray.
    do_run(0, 0, 0, '{enables: 0, done_cyc: 1, err: 1'b0, ecnt: 8'd0, last: 5'b00010, ab: 1'b0});

    // Start during RUN is ignored.
    preset(5'd0);
    do_run(5, 0, 3, '{enables: 5, done_cyc: 9, err: 1'b0, ecnt: 8'd0, last: 5'b00111, ab: 1'b0});

    // Asynchronous reset mid-run with errors accumulated.
    preset(5'd0);
    mask = 5'b00001;
    @(negedge clk);
    bus.start = 1'b1;
    bus.num_counts = 8'd10;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_running", bus.enable, 1);
    chk("pre_reset_errs", (bus.error_count != '0), 1);
    #2;
    reset_L = 1'b0;
    #1;
    chk("async_enable", bus.enable, 0);
    chk("async_busy", bus.busy, 0);
    chk("async_error_count", bus.error_count, 0);
    mask = '0;
    @(negedge clk);
    reset_L = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_reset_idle_busy", bus.busy, 0);
      chk("post_reset_no_done", bus.done, 0);
    end
    preset(5'd0);
    do_run(4, 0, 0, '{enables: 4, done_cyc: 8, err: 1'b0, ecnt: 8'd0, last: 5'b00110, ab: 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
